regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 35 +++
 rtl/regfile_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the result producers (ALU, load, mul/div) and the
// register-file writeback arbiter. It carries the per-requester write
// handshakes, the registered register-file write port, and the issue and
// operand-lookup signals used by the pending-write scoreboard.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*5-1:0]  req_wn;
  logic [NREQ*32-1:0] req_d;
  logic [NREQ-1:0]    req_ready;

  logic               we;
  logic [4:0]         wn;
  logic [31:0]        d;

  logic               iss_valid;
  logic [4:0]         iss_wn;
  logic [4:0]         rna;
  logic [4:0]         rnb;
  logic               busy_a;
  logic               busy_b;

  // Producer / pipeline side.
  modport master (
    output req_valid, req_wn, req_d, iss_valid, iss_wn, rna, rnb,
    input  req_ready, we, wn, d, busy_a, busy_b
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_wn, req_d, iss_valid, iss_wn, rna, rnb,
    output req_ready, we, wn, d, busy_a, busy_b
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Up to four result producers compete for the single register-file write
// port. A round-robin arbiter picks one producer per cycle, and the winner's
// register number and data appear on the registered write port one cycle
// later. Writes to r0 are accepted but never reach the register file.
//
// Optional feature: define REGFILE_WB_SCOREBOARD_EN to build the pending-write
// scoreboard. The scoreboard tracks issued-but-not-yet-written destinations
// and reports busy_a/busy_b for the two source operands. When the macro is
// left undefined there is no scoreboard state and busy_a/busy_b are tied to 0.
//
// clr is a synchronous, active-high reset.
module regfile_wb_arbiter #(
  parameter int NREQ = 3
) (
  input logic                  clk,
  input logic                  clr,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NREQ);
  endfunction

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          we_q, we_d;
  logic [4:0]    wn_q, wn_d;
  logic [31:0]   d_q, d_d;

  logic          gnt_any;
  logic [PW-1:0] gnt_idx;
  logic [NREQ-1:0] ready;
  logic          xfer;
  logic [4:0]    sel_wn;
  logic [31:0]   sel_d;

  // Round-robin search: walk from rr_ptr upward (wrapping) and keep the
  // requester nearest to the pointer.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves it unassigned and no latch is inferred.
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[wrap(int'(rr_ptr_q) + k)]) begin
        gnt_any = 1'b1;
        gnt_idx = wrap(int'(rr_ptr_q) + k);
      end
    end
  end

  // One-hot ready to the winner; suppressed entirely while clr is high.
  always_comb begin
    ready = '0;
    if (gnt_any && !clr) ready[gnt_idx] = 1'b1;
  end

  assign bus.req_ready = ready;
  assign xfer          = gnt_any && !clr;
  assign sel_wn        = bus.req_wn[int'(gnt_idx)*5 +: 5];
  assign sel_d         = bus.req_d[int'(gnt_idx)*32 +: 32];

  // Next-state for the pointer and the registered write port. A write to r0
  // is accepted but produces no write enable.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we_d     = 1'b0;
    wn_d     = wn_q;
    d_d      = d_q;
    if (xfer) begin
      rr_ptr_d = wrap(int'(gnt_idx) + 1);
      we_d     = (sel_wn != 5'd0);
      wn_d     = sel_wn;
      d_d      = sel_d;
    end
  end

  // Arbiter and write-port state; clr overrides any transfer this cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (clr) begin
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      wn_q     <= '0;
      d_q      <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      wn_q     <= wn_d;
      d_q      <= d_d;
    end
  end

  assign bus.we = we_q;
  assign bus.wn = wn_q;
  assign bus.d  = d_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [31:1] sb_q, sb_d;
  logic [31:0] sb_full;

  // Pending bits: the write port clears, a new issue sets; the issue is
  // applied last so a new producer wins over a retiring one.
  always_comb begin
    sb_d = sb_q;
    if (we_q && wn_q != 5'd0) sb_d[wn_q] = 1'b0;
    if (bus.iss_valid && bus.iss_wn != 5'd0) sb_d[bus.iss_wn] = 1'b1;
  end

  // Scoreboard state, cleared by clr.
  always_ff @(posedge clk) begin
    // NOTE: these 31 bits are control state, not data storage, so they are
    // reset; a stale pending bit would stall the pipeline forever.
    if (clr) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  // r0 maps to a constant-zero bit, so it is never busy.
  assign sb_full    = {sb_q, 1'b0};
  assign bus.busy_a = sb_full[bus.rna] & ~(we_q && wn_q == bus.rna);
  assign bus.busy_b = sb_full[bus.rnb] & ~(we_q && wn_q == bus.rnb);
`else
  logic unused_sb_inputs;

  assign unused_sb_inputs = ^{bus.iss_valid, bus.iss_wn, bus.rna, bus.rnb};
  assign bus.busy_a       = 1'b0;
  assign bus.busy_b       = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter (NREQ = 3).
// Busy expectations follow REGFILE_WB_SCOREBOARD_EN: the scoreboard
// expectations apply when the macro is defined, constant 0 otherwise.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
`ifdef REGFILE_WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NREQ(NREQ)) bus ();

  regfile_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] w, input logic [31:0] dd);
    bus.req_valid[i]        = v;
    bus.req_wn[i*5 +: 5]    = w;
    bus.req_d[i*32 +: 32]   = dd;
  endtask

  // Random-phase model state
  logic        hold [NREQ];
  int          wait_c [NREQ];
  logic [4:0]  hwn [NREQ];
  logic [31:0] hd [NREQ];
  int          m_ptr;
  int          g;
  logic        exp_we;
  logic [4:0]  exp_wn;
  logic [31:0] exp_d;
  logic [NREQ-1:0] exp_ready;

  initial begin
    clr           = 1'b1;
    bus.req_valid = '0;
    bus.req_wn    = '0;
    bus.req_d     = '0;
    bus.iss_valid = 1'b0;
    bus.iss_wn    = '0;
    bus.rna       = '0;
    bus.rnb       = '0;

    // Reset: ready stays low even with every requester valid.
    set_req(0, 1'b1, 5'd1, 32'hA);
    set_req(1, 1'b1, 5'd2, 32'hB);
    set_req(2, 1'b1, 5'd3, 32'hC);
    settle();
    check("rst_ready", bus.req_ready, 3'b000);
    tick();
    tick();
    check("rst_we", bus.we, 1'b0);
    check("rst_wn", bus.wn, 5'd0);
    check("rst_d", bus.d, 32'h0);
    check("rst_busy_a", bus.busy_a, 1'b0);

    // All three valid: grants 0,1,2 in order, writes r1,r2,r3.
    clr = 1'b0;
    settle();
    check("rr_ready0", bus.req_ready, 3'b001);
    tick();
    check("rr_we1", bus.we, 1'b1);
    check("rr_wn1", bus.wn, 5'd1);
    check("rr_d1", bus.d, 32'hA);
    check("rr_ready1", bus.req_ready, 3'b010);
    tick();
    check("rr_wn2", bus.wn, 5'd2);
    check("rr_d2", bus.d, 32'hB);
    check("rr_ready2", bus.req_ready, 3'b100);
    tick();
    bus.req_valid = '0;
    settle();
    check("rr_we3", bus.we, 1'b1);
    check("rr_wn3", bus.wn, 5'd3);
    check("rr_d3", bus.d, 32'hC);
    check("idle_ready", bus.req_ready, 3'b000);
    tick();
    check("idle_we", bus.we, 1'b0);
    check("idle_wn_hold", bus.wn, 5'd3);
    check("idle_d_hold", bus.d, 32'hC);

    // Only requester 2: immediate ready, write one cycle later, pointer wraps to 0.
    set_req(2, 1'b1, 5'd5, 32'hDEADBEEF);
    settle();
    check("r2_ready", bus.req_ready, 3'b100);
    tick();
    bus.req_valid = '0;
    settle();
    check("r2_we", bus.we, 1'b1);
    check("r2_wn", bus.wn, 5'd5);
    check("r2_d", bus.d, 32'hDEADBEEF);
    bus.req_valid = 3'b011;
    settle();
    check("r2_ptr0", bus.req_ready, 3'b001);
    bus.req_valid = '0;
    tick();
    check("r2_we_off", bus.we, 1'b0);

    // Write to r0: accepted, no write enable; pointer moves to 2.
    set_req(1, 1'b1, 5'd0, 32'h1234);
    settle();
    check("r0_ready", bus.req_ready, 3'b010);
    tick();
    bus.req_valid = '0;
    settle();
    check("r0_we", bus.we, 1'b0);
    bus.req_valid = 3'b011;
    settle();
    check("wrap_ready", bus.req_ready, 3'b001);
    bus.req_valid = 3'b110;
    settle();
    check("ptr2_ready", bus.req_ready, 3'b100);
    bus.req_valid = '0;
    tick();

    // Scoreboard: issue r7, retire it through requester 0.
    bus.iss_valid = 1'b1;
    bus.iss_wn    = 5'd7;
    bus.rna       = 5'd7;
    bus.rnb       = 5'd0;
    settle();
    check("sb_pre_busy", bus.busy_a, 1'b0);
    tick();
    bus.iss_valid = 1'b0;
    settle();
    check("sb_busy_a", bus.busy_a, SB);
    check("sb_r0_busy", bus.busy_b, 1'b0);
    bus.rnb = 5'd7;
    settle();
    check("sb_busy_b", bus.busy_b, SB);
    set_req(0, 1'b1, 5'd7, 32'h77);
    settle();
    check("sb_wr_ready", bus.req_ready, 3'b001);
    check("sb_busy_hold", bus.busy_a, SB);
    tick();
    bus.req_valid = '0;
    settle();
    check("sb_wr_we", bus.we, 1'b1);
    check("sb_wr_wn", bus.wn, 5'd7);
    check("sb_bypass", bus.busy_a, 1'b0);
    tick();
    check("sb_cleared", bus.busy_a, 1'b0);

    // Re-issue r7 in the same cycle it retires: new producer wins.
    bus.iss_valid = 1'b1;
    tick();
    bus.iss_valid = 1'b0;
    settle();
    check("sb2_busy", bus.busy_a, SB);
    set_req(0, 1'b1, 5'd7, 32'h88);
    settle();
    check("sb2_ready", bus.req_ready, 3'b001);
    tick();
    bus.req_valid = '0;
    bus.iss_valid = 1'b1;
    settle();
    check("sb2_bypass", bus.busy_a, 1'b0);
    tick();
    bus.iss_valid = 1'b0;
    settle();
    check("sb2_reissue", bus.busy_a, SB);

    // Reset priority: r4 pending, a write in flight, all requesters valid.
    bus.iss_valid = 1'b1;
    bus.iss_wn    = 5'd4;
    tick();
    bus.iss_valid = 1'b0;
    bus.rna       = 5'd4;
    settle();
    check("clr_pre_busy", bus.busy_a, SB);
    set_req(0, 1'b1, 5'd1, 32'hA);
    set_req(1, 1'b1, 5'd2, 32'hB);
    set_req(2, 1'b1, 5'd3, 32'hC);
    settle();
    check("clr_pre_ready", bus.req_ready, 3'b010);
    tick();
    clr = 1'b1;
    settle();
    check("clr_ready", bus.req_ready, 3'b000);
    check("clr_inflight_we", bus.we, 1'b1);
    check("clr_inflight_wn", bus.wn, 5'd2);
    tick();
    check("clr_we", bus.we, 1'b0);
    check("clr_wn", bus.wn, 5'd0);
    check("clr_d", bus.d, 32'h0);
    check("clr_busy_r4", bus.busy_a, 1'b0);
    check("clr_busy_r7", bus.busy_b, 1'b0);
    clr = 1'b0;
    settle();
    check("clr_first_grant", bus.req_ready, 3'b001);
    bus.req_valid = '0;
    tick();

    // Random held requests against a round-robin model (pointer is 0 here).
    m_ptr  = 0;
    exp_we = 1'b0;
    exp_wn = '0;
    exp_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      hold[i]   = 1'b0;
      wait_c[i] = 0;
      hwn[i]    = '0;
      hd[i]     = '0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      check("rnd_we", bus.we, exp_we);
      if (exp_we) begin
        check("rnd_wn", bus.wn, exp_wn);
        check("rnd_d", bus.d, exp_d);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!hold[i] && $urandom_range(0, 1) == 1) begin
          hold[i]   = 1'b1;
          wait_c[i] = 0;
          hwn[i]    = 5'($urandom_range(0, 31));
          hd[i]     = $urandom;
        end
        set_req(i, hold[i], hwn[i], hd[i]);
      end
      settle();
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && hold[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("rnd_ready", bus.req_ready, exp_ready);
      exp_we = 1'b0;
      if (g >= 0) begin
        check("rnd_starve", (wait_c[g] < NREQ), 1'b1);
        exp_we  = (hwn[g] != 5'd0);
        exp_wn  = hwn[g];
        exp_d   = hd[g];
        hold[g] = 1'b0;
        m_ptr   = (g + 1) % NREQ;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (hold[i]) wait_c[i]++;
      end
      tick();
    end
    check("rnd_we_last", bus.we, exp_we);
    if (exp_we) check("rnd_wn_last", bus.wn, exp_wn);
    bus.req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
